// File: rtl/uart_rx_ctrl_if.sv
// Receive-side signal bundle for uart_rx_ctrl: serial line in, byte/status out.
// The controller uses the master view and the consumer uses the slave view.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic                 data_ready;
    logic                 clr_status;
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_valid;
    logic                 baud_align;
    logic                 busy;
    logic                 framing_error;
    logic                 false_start;
    logic                 overrun;

    modport master (
        input  rx, data_ready, clr_status,
        output rx_data, data_valid, baud_align, busy,
               framing_error, false_start, overrun
    );

    modport slave (
        output rx, data_ready, clr_status,
        input  rx_data, data_valid, baud_align, busy,
               framing_error, false_start, overrun
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART frame receiver: start validation, mid-bit sampling, LSB-first assembly,
// stop check, and a one-entry valid/ready output buffer with sticky overrun.
module uart_rx_ctrl #(
    parameter int CLK_FREQ_HZ = 1_600_000,
    parameter int BAUD_RATE   = 100_000,
    parameter int DATA_BITS   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_ctrl_if.master bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 s1_reg, rx_s_reg;
    logic                 align_reg, align_next;
    logic                 fe_reg, fe_next;
    logic                 fs_reg, fs_next;
    logic                 ov_reg;
    logic                 cnt_clr;
    logic                 sample_bit;
    logic                 deliver;
    logic                 xfer;

    // Two-flop synchroniser; idle-high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_reg   <= 1'b1;
            rx_s_reg <= 1'b1;
        end else begin
            s1_reg   <= bus.rx;
            rx_s_reg <= s1_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        cnt_clr      = 1'b0;
        sample_bit   = 1'b0;
        deliver      = 1'b0;
        align_next   = 1'b0;
        fe_next      = 1'b0;
        fs_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s_reg) begin
                    state_next = START;
                    align_next = 1'b1;
                end
            end
            START: begin
                if (cnt_reg == CNT_W'(HALF - 1)) begin
                    if (!rx_s_reg) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        fs_next    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
                    sample_bit   = 1'b1;
                    cnt_clr      = 1'b1;
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == IDX_W'(DATA_BITS - 1))
                        state_next = STOP;
                end
            end
            STOP: begin
                if (cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
                    if (rx_s_reg) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        fe_next    = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s_reg)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter restarts on every state change and on each data-bit sample.
    assign cnt_next = (cnt_clr || (state_next != state_reg)) ? '0 : cnt_reg + 1'b1;

    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            assign shift_next[gi] = (sample_bit && (bit_idx_reg == IDX_W'(gi)))
                                    ? rx_s_reg : shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            align_reg   <= 1'b0;
            fe_reg      <= 1'b0;
            fs_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            align_reg   <= align_next;
            fe_reg      <= fe_next;
            fs_reg      <= fs_next;
        end
    end

    assign xfer = valid_reg && bus.data_ready;

    // A delivery coinciding with a transfer refills the buffer; otherwise a full buffer drops it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ov_reg    <= 1'b0;
        end else begin
            if (deliver && (!valid_reg || xfer)) begin
                data_reg  <= shift_reg;
                valid_reg <= 1'b1;
            end else if (xfer) begin
                valid_reg <= 1'b0;
            end
            if (deliver && valid_reg && !bus.data_ready)
                ov_reg <= 1'b1;
            else if (bus.clr_status)
                ov_reg <= 1'b0;
        end
    end

    assign bus.rx_data       = data_reg;
    assign bus.data_valid    = valid_reg;
    assign bus.baud_align    = align_reg;
    assign bus.busy          = (state_reg != IDLE);
    assign bus.framing_error = fe_reg;
    assign bus.false_start   = fs_reg;
    assign bus.overrun       = ov_reg;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit; edge numbers are
// relative to the first edge at which the synchroniser sees the start bit.
module tb_uart_rx_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_ctrl_if #(.DATA_BITS(8)) bus ();

    uart_rx_ctrl #(
        .CLK_FREQ_HZ(1_600_000),
        .BAUD_RATE  (100_000),
        .DATA_BITS  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e0    = 0;
    logic [13:0] snap = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: pulses and valid cycles on the falling edge, transfers on the rising edge.
    int ba_cnt = 0, ba_cyc = 0;
    int fs_cnt = 0, fs_cyc = 0;
    int fe_cnt = 0, fe_cyc = 0;
    int dv_cycles = 0, dv_rise_cyc = 0;
    int xfer_cnt = 0;
    logic [7:0] dv_data = '0;
    logic [7:0] xfer_data = '0;
    logic dv_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.baud_align) begin ba_cnt++; ba_cyc = cyc; end
        if (bus.false_start) begin fs_cnt++; fs_cyc = cyc; end
        if (bus.framing_error) begin fe_cnt++; fe_cyc = cyc; end
        if (bus.data_valid) begin
            dv_cycles++;
            dv_data = bus.rx_data;
            if (!dv_prev) dv_rise_cyc = cyc;
        end
        dv_prev = bus.data_valid;
    end

    always @(posedge clk) begin
        if (bus.data_valid && bus.data_ready) begin
            xfer_cnt++;
            xfer_data = bus.rx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Drives one 10-bit frame; optionally pulses data_ready or rst_n at frame edge k.
    task automatic frame(input logic [7:0] d, input logic stop, input int rdy_k, input int rst_k);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int k = 0; k < 160; k++) begin
            tick(1);
            if (rst_k >= 0 && k == rst_k + 1)
                snap = {bus.rx_data, bus.data_valid, bus.baud_align, bus.busy,
                        bus.framing_error, bus.false_start, bus.overrun};
            if (k == 0) e0 = cyc + 1;
            bus.rx = bits[k / 16];
            if (rdy_k >= 0 && k == rdy_k) bus.data_ready = 1'b1;
            else if (rdy_k >= 0 && k == rdy_k + 1) bus.data_ready = 1'b0;
            rst_n = (rst_k >= 0 && k == rst_k) ? 1'b0 : 1'b1;
        end
    endtask

    int ba0, fs0, fe0, dv0, xf0;

    task automatic mark();
        ba0 = ba_cnt; fs0 = fs_cnt; fe0 = fe_cnt; dv0 = dv_cycles; xf0 = xfer_cnt;
    endtask

    initial begin
        bus.rx = 1'b1;
        bus.data_ready = 1'b0;
        bus.clr_status = 1'b0;
        rst_n = 1'b0;
        tick(3);
        snap = {bus.rx_data, bus.data_valid, bus.baud_align, bus.busy,
                bus.framing_error, bus.false_start, bus.overrun};
        check("reset_outputs", 32'(snap), 32'h0);
        rst_n = 1'b1;
        tick(5);

        // 0xA5 with the consumer always ready
        bus.data_ready = 1'b1;
        mark();
        frame(8'hA5, 1'b1, -1, -1);
        tick(2);
        check("a5_data", 32'(dv_data), 32'hA5);
        check("a5_align_cnt", 32'(ba_cnt - ba0), 32'd1);
        check("a5_align_edge", 32'(ba_cyc - e0), 32'd2);
        check("a5_valid_edge", 32'(dv_rise_cyc - e0), 32'd154);
        check("a5_valid_cycles", 32'(dv_cycles - dv0), 32'd1);
        check("a5_status", 32'((fe_cnt - fe0) + (fs_cnt - fs0)), 32'd0);
        check("a5_busy", 32'(bus.busy), 32'd0);
        check("a5_overrun", 32'(bus.overrun), 32'd0);

        // 5-clock low glitch
        mark();
        tick(1);
        e0 = cyc + 1;
        bus.rx = 1'b0;
        tick(5);
        bus.rx = 1'b1;
        tick(20);
        check("glitch_align_cnt", 32'(ba_cnt - ba0), 32'd1);
        check("glitch_fs_cnt", 32'(fs_cnt - fs0), 32'd1);
        check("glitch_fs_edge", 32'(fs_cyc - e0), 32'd10);
        check("glitch_valid", 32'(dv_cycles - dv0), 32'd0);
        check("glitch_busy", 32'(bus.busy), 32'd0);

        // 0x3C with a bad stop bit, line held low, then 0x55
        mark();
        frame(8'h3C, 1'b0, -1, -1);
        tick(40);
        check("fe_cnt", 32'(fe_cnt - fe0), 32'd1);
        check("fe_edge", 32'(fe_cyc - e0), 32'd154);
        check("fe_valid", 32'(dv_cycles - dv0), 32'd0);
        check("fe_busy_held", 32'(bus.busy), 32'd1);
        bus.rx = 1'b1;
        tick(4);
        check("fe_busy_released", 32'(bus.busy), 32'd0);
        mark();
        frame(8'h55, 1'b1, -1, -1);
        tick(2);
        check("after_fe_data", 32'(dv_data), 32'h55);
        check("after_fe_valid_cycles", 32'(dv_cycles - dv0), 32'd1);
        check("after_fe_fe", 32'(fe_cnt - fe0), 32'd0);

        // Overrun: two frames with the consumer stalled
        bus.data_ready = 1'b0;
        tick(4);
        frame(8'h11, 1'b1, -1, -1);
        frame(8'h22, 1'b1, -1, -1);
        tick(2);
        check("ovr_data_kept", 32'(bus.rx_data), 32'h11);
        check("ovr_valid", 32'(bus.data_valid), 32'd1);
        check("ovr_flag", 32'(bus.overrun), 32'd1);
        bus.data_ready = 1'b1;
        tick(1);
        bus.data_ready = 1'b0;
        check("ovr_xfer_data", 32'(xfer_data), 32'h11);
        check("ovr_valid_after_xfer", 32'(bus.data_valid), 32'd0);
        check("ovr_data_not_cleared", 32'(bus.rx_data), 32'h11);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);
        bus.clr_status = 1'b1;
        tick(1);
        bus.clr_status = 1'b0;
        check("ovr_cleared", 32'(bus.overrun), 32'd0);

        // Ready on the exact delivery edge of the second byte
        tick(4);
        frame(8'h11, 1'b1, -1, -1);
        mark();
        frame(8'h22, 1'b1, 154, -1);
        tick(2);
        check("same_edge_xfer_cnt", 32'(xfer_cnt - xf0), 32'd1);
        check("same_edge_xfer_data", 32'(xfer_data), 32'h11);
        check("same_edge_data", 32'(bus.rx_data), 32'h22);
        check("same_edge_valid", 32'(bus.data_valid), 32'd1);
        check("same_edge_overrun", 32'(bus.overrun), 32'd0);

        // Reset pulse during bit 4, then 0xFF
        mark();
        frame(8'hF0, 1'b1, -1, 85);
        tick(20);
        check("midreset_outputs", 32'(snap), 32'h0);
        check("midreset_fe", 32'(fe_cnt - fe0), 32'd0);
        check("midreset_fs", 32'(fs_cnt - fs0), 32'd0);
        check("midreset_valid", 32'(bus.data_valid), 32'd0);
        bus.data_ready = 1'b1;
        mark();
        frame(8'hFF, 1'b1, -1, -1);
        tick(2);
        check("ff_data", 32'(dv_data), 32'hFF);
        check("ff_valid_edge", 32'(dv_rise_cyc - e0), 32'd154);
        check("ff_valid_cycles", 32'(dv_cycles - dv0), 32'd1);
        check("ff_status", 32'((fe_cnt - fe0) + (fs_cnt - fs0)), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
